// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: word size,
// operation encodings and the sequencer states.
package mult_div_unit_pkg;

   localparam int WORD_SIZE = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIN  = 2'b10
   } state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: magnitudes are processed one bit per
// cycle on a shared accumulator and a single add/sub, then signs are fixed.
module mult_div_unit #(
   parameter int WORD_SIZE = mult_div_unit_pkg::WORD_SIZE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [WORD_SIZE-1:0] rs_data,
   input  logic [WORD_SIZE-1:0] rt_data,
   input  logic                 mthi,
   input  logic                 mtlo,
   output logic                 busy,
   output logic                 done,
   output logic [WORD_SIZE-1:0] hi,
   output logic [WORD_SIZE-1:0] lo
);
   import mult_div_unit_pkg::*;

   localparam int W  = WORD_SIZE;
   localparam int CW = $clog2(WORD_SIZE);
   localparam logic [W-1:0]   ONE_W    = {{(W-1){1'b0}}, 1'b1};
   localparam logic [2*W-1:0] ONE_2W   = {{(2*W-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]  CNT_LAST = CW'(WORD_SIZE - 1);

   state_e           state_q, state_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     hi_q, hi_d;
   logic [W-1:0]     lo_q, lo_d;
   logic             div_q, div_d;
   logic             neg_q, neg_d;
   logic             rneg_q, rneg_d;
   logic             dz_q, dz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             op_signed, op_div;
   logic [W-1:0]     a_mag, b_mag;
   logic [W:0]       part_rem, add_a;
   logic [W+1:0]     add_b, add_sum;
   logic             add_cin;
   logic [2*W-1:0]   acc_step, prod_fix;
   logic [W-1:0]     quo_fix, rem_fix;

   // Decode the request and take operand magnitudes for signed ops
   always_comb begin
      op_signed = (op == OP_MULT) || (op == OP_DIV);
      op_div    = (op == OP_DIV) || (op == OP_DIVU);
      if (op_signed && rs_data[W-1]) begin
         a_mag = ~rs_data + ONE_W;
      end else begin
         a_mag = rs_data;
      end
      if (op_signed && rt_data[W-1]) begin
         b_mag = ~rt_data + ONE_W;
      end else begin
         b_mag = rt_data;
      end
   end

   // Shared adder: adds the multiplicand, or trial-subtracts the divisor
   // from the left-shifted partial remainder (W+1 bits, so no bit is lost)
   always_comb begin
      part_rem = acc_q[2*W-1:W-1];
      if (div_q) begin
         add_a   = part_rem;
         add_b   = ~{2'b00, b_q};
         add_cin = 1'b1;
      end else begin
         add_a   = {1'b0, acc_q[2*W-1:W]};
         add_b   = {2'b00, b_q};
         add_cin = 1'b0;
      end
      add_sum = {1'b0, add_a} + add_b + {{(W+1){1'b0}}, add_cin};
      if (div_q) begin
         if (add_sum[W+1]) begin
            acc_step = {part_rem[W-1:0], acc_q[W-2:0], 1'b0};
         end else begin
            acc_step = {add_sum[W-1:0], acc_q[W-2:0], 1'b1};
         end
      end else begin
         if (acc_q[0]) begin
            acc_step = {add_sum[W:0], acc_q[W-1:1]};
         end else begin
            acc_step = {1'b0, acc_q[2*W-1:W], acc_q[W-1:1]};
         end
      end
   end

   // Sign-corrected results presented to HI/LO in the final state
   always_comb begin
      if (neg_q) begin
         prod_fix = ~acc_q + ONE_2W;
      end else begin
         prod_fix = acc_q;
      end
      if (dz_q) begin
         quo_fix = {W{1'b1}};
      end else if (neg_q) begin
         quo_fix = ~acc_q[W-1:0] + ONE_W;
      end else begin
         quo_fix = acc_q[W-1:0];
      end
      if (rneg_q) begin
         rem_fix = ~acc_q[2*W-1:W] + ONE_W;
      end else begin
         rem_fix = acc_q[2*W-1:W];
      end
   end

   // Sequencer next state and datapath register updates
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      b_d     = b_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               acc_d   = {{W{1'b0}}, a_mag};
               b_d     = b_mag;
               div_d   = op_div;
               neg_d   = op_signed && (rs_data[W-1] ^ rt_data[W-1]);
               rneg_d  = op_signed && rs_data[W-1];
               dz_d    = (rt_data == {W{1'b0}});
               cnt_d   = {CW{1'b0}};
               busy_d  = 1'b1;
               state_d = ST_CALC;
            end else begin
               if (mthi) begin
                  hi_d = rs_data;
               end else begin
                  hi_d = hi_q;
               end
               if (mtlo) begin
                  lo_d = rs_data;
               end else begin
                  lo_d = lo_q;
               end
            end
         end
         ST_CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FIN;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_FIN: begin
            if (div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*W-1:W];
               lo_d = prod_fix[W-1:0];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         acc_q   <= {(2*W){1'b0}};
         cnt_q   <= {CW{1'b0}};
         b_q     <= {W{1'b0}};
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= {W{1'b0}};
         lo_q    <= {W{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         b_q     <= b_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: an arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed HI/LO values and latencies.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs_data = 32'd0;
   logic [31:0] rt_data = 32'd0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;

   mult_div_unit #(.WORD_SIZE(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference result {HI, LO} from plain integer arithmetic
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
      logic signed [63:0] sa, sb, q, rm;
      logic [63:0] r;
      sa = $signed(a);
      sb = $signed(b);
      case (o)
         2'b00: r = sa * sb;
         2'b01: r = {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 32'd0) begin
               r = {a, 32'hFFFFFFFF};
            end else begin
               q  = sa / sb;
               rm = sa % sb;
               r  = {rm[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) r = {a, 32'hFFFFFFFF};
            else            r = {a % b, a / b};
         end
      endcase
      return r;
   endfunction

   logic        m_busy, m_done;
   logic [31:0] m_hi, m_lo;
   logic [63:0] m_res;
   int          m_cnt;

   // Architectural model: 33 cycles from accepted start to HI/LO update
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_hi <= 32'd0; m_lo <= 32'd0;
         m_cnt  <= 0;    m_res  <= 64'd0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_hi   <= m_res[63:32];
               m_lo   <= m_res[31:0];
            end
         end else if (start) begin
            m_busy <= 1'b1;
            m_cnt  <= 33;
            m_res  <= ref_result(op, rs_data, rt_data);
         end else begin
            if (mthi) m_hi <= rs_data;
            if (mtlo) m_lo <= rs_data;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(posedge clk) begin
      #1;
      check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
      check("cyc_done", {31'd0, done}, {31'd0, m_done});
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
   end

   // Called and returning at a falling edge
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic mv, input string nm);
      int lat;
      start = 1'b1; op = o; rs_data = a; rt_data = b; mthi = mv; mtlo = mv;
      @(negedge clk);
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      rs_data = $urandom; rt_data = $urandom;
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({nm, "_lat"}, 32'(lat), 32'd33);
      check({nm, "_hi"}, hi, exp_hi);
      check({nm, "_lo"}, lo, exp_lo);
      @(negedge clk);
      check({nm, "_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ndone, dlat;
      repeat (3) @(negedge clk);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);

      // Release reset and start at the same falling edge
      rst = 1'b1;
      run_op(2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, "mult_neg");
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max");
      run_op(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7_2");
      run_op(2'b11, 32'd10,       32'd0,        32'h0000000A, 32'hFFFFFFFF, 1'b0, "divu_zero");
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_ovf");
      run_op(2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_7_m2");
      run_op(2'b10, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b0, "div_m8_zero");
      run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_min");
      run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, "mult_m1");
      run_op(2'b11, 32'hFFFFFFFF, 32'd3,        32'h00000000, 32'h55555555, 1'b0, "divu_third");
      run_op(2'b01, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, "multu_shift");
      // start wins over simultaneous moves
      run_op(2'b11, 32'd20,       32'd3,        32'h00000002, 32'h00000006, 1'b1, "start_vs_mv");

      // Both moves together
      mthi = 1'b1; mtlo = 1'b1; rs_data = 32'h5555AAAA;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
      check("mv_both_hi", hi, 32'h5555AAAA);
      check("mv_both_lo", lo, 32'h5555AAAA);

      // Requests while busy are ignored
      start = 1'b1; op = 2'b11; rs_data = 32'd100; rt_data = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; mthi = 1'b1; op = 2'b00; rs_data = 32'h1234; rt_data = 32'd9;
      @(negedge clk);
      start = 1'b0; mthi = 1'b0;
      ndone = 0; dlat = 0;
      for (int k = 6; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            dlat = k;
         end
      end
      check("busy_ign_ndone", 32'(ndone), 32'd1);
      check("busy_ign_lat", 32'(dlat), 32'd33);
      check("busy_ign_lo", lo, 32'd14);
      check("busy_ign_hi", hi, 32'd2);

      // Reset mid-operation aborts without a result
      mthi = 1'b1; rs_data = 32'h0000AAAA;
      @(negedge clk);
      mthi = 1'b0;
      check("mthi_hi", hi, 32'h0000AAAA);
      start = 1'b1; op = 2'b00; rs_data = 32'd2; rt_data = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort_ndone", 32'(ndone), 32'd0);
      mtlo = 1'b1; rs_data = 32'd7;
      @(negedge clk);
      mtlo = 1'b0;
      check("mtlo_lo", lo, 32'd7);
      check("mtlo_hi", hi, 32'd0);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, giving the operand and HI/LO register width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: asynchronous and active-low (asserted at 0).
REQ-004 SHALL have port start, input, 1, a request to begin the operation given by op.
REQ-005 SHALL have port op, input, 2, the operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port rs_data, input, WORD_SIZE, the register-file read_data1 (multiplicand or dividend).
REQ-007 SHALL have port rt_data, input, WORD_SIZE, the register-file read_data2 (multiplier or divisor).
REQ-008 SHALL have port mthi, input, 1, which writes rs_data into HI.
REQ-009 SHALL have port mtlo, input, 1, which writes rs_data into LO.
REQ-010 SHALL have port busy, output, 1, asserted while an operation is in flight.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse when HI/LO take a new result.
REQ-012 SHALL have ports hi and lo, output, WORD_SIZE each, the architectural HI/LO values feeding the register-file write_data mux (MFHI/MFLO).

Function
REQ-013 SHALL implement the states IDLE, CALC and FIN, and no others.
REQ-014 In IDLE with start=1 at edge N: SHALL latch |operands| (signed ops) or raw operands, record the result signs, clear the iteration counter, go to CALC, and drive busy=1 from after edge N.
REQ-015 In CALC: SHALL perform exactly one iteration per edge (shift-add for multiply, restoring shift-subtract for divide) on a 2*WORD_SIZE accumulator, for WORD_SIZE iterations (edges N+1..N+32); the counter wraps 31->0 as the state goes to FIN.
REQ-016 In FIN at edge N+33: SHALL apply sign correction, write HI/LO, pulse done=1 for that cycle, drive busy=0, and return to IDLE; total latency is 33 cycles from start to visible HI/LO.
REQ-017 MULT/MULTU SHALL place the product with HI=upper word and LO=lower word; signed results SHALL be two's complement.
REQ-018 DIV/DIVU SHALL place the quotient in LO and the remainder in HI; the signed quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-019 On divide by zero: LO SHALL be all ones and HI SHALL be the dividend, with the normal 33-cycle latency.
REQ-020 On DIV 0x80000000 / 0xFFFFFFFF: LO SHALL be 0x80000000 and HI SHALL be 0.
REQ-021 start, mthi and mtlo SHALL be ignored while busy=1; HI/LO SHALL hold their old values until FIN.
REQ-022 In IDLE, mthi/mtlo SHALL update HI/LO at the next edge; mthi and mtlo together SHALL write both.
REQ-023 If start and mthi/mtlo are asserted together in IDLE: start SHALL win, and the move SHALL be dropped.
REQ-024 Operands SHALL be sampled only at the start edge; later changes to rs_data/rt_data SHALL have no effect.
REQ-025 hi and lo SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-026 While rst=0: state=IDLE, HI=LO=0, accumulator and counter=0, busy=0, done=0, independent of clk.
REQ-027 Reset mid-operation SHALL abort the operation without any HI/LO update or done pulse.
REQ-028 After rst deasserts, the first start SHALL be accepted at the first rising edge.

Structure
REQ-029 A shared package SHALL hold WORD_SIZE, the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state enum.
REQ-030 The design SHALL be a single module with no sub-module; multiply and divide share one accumulator and one adder/subtractor.

Verification
REQ-031 MULT rs=0xFFFFFFFD (-3), rt=5 -> done at +33 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 10/0 -> LO=0xFFFFFFFF, HI=0x0000000A.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
REQ-035 start DIVU 100/7, then pulse start and mthi (rs=0x1234) at +5 cycles -> both ignored; at +33 LO=14, HI=2, single done pulse.
REQ-036 mthi=1 with rs=0xAAAA in IDLE, then start MULT 2x3, then rst=0 at +10 cycles -> HI=LO=0, busy=0, no done pulse; after release, MTLO rs=7 -> LO=7 next edge.
